// File: rtl/multicycle_controller_if.sv
// Handshake/control bundle between the multicycle controller and the shared datapath and memory.
// The slave modport is the controller side; master is the datapath/memory (or bench) side.
interface multicycle_controller_if #(
   parameter int OP_W  = 3,
   parameter int CNT_W = 16
);
   logic             start;
   logic [OP_W-1:0]  op;
   logic             zero;
   logic             mem_ready;
   logic             mem_read;
   logic             memW;
   logic             ir_en;
   logic             pc_en;
   logic             pc_src;
   logic             regW;
   logic             mem_to_reg;
   logic             addition;
   logic             aluF;
   logic             branch;
   logic             busy;
   logic             halted;
   logic             illegal;
   logic             timeout;
   logic [CNT_W-1:0] instr_count;

   modport master (
      output start, op, zero, mem_ready,
      input  mem_read, memW, ir_en, pc_en, pc_src, regW, mem_to_reg,
             addition, aluF, branch, busy, halted, illegal, timeout, instr_count
   );

   modport slave (
      input  start, op, zero, mem_ready,
      output mem_read, memW, ir_en, pc_en, pc_src, regW, mem_to_reg,
             addition, aluF, branch, busy, halted, illegal, timeout, instr_count
   );
endinterface

// File: rtl/multicycle_controller.sv
// Multi-cycle sequencer for the 3-bit ISA (store/load/add/beq/halt) with memory-ready
// handshake, memory wait timeout, sticky fault flags and a saturating retire counter.
//
// state  | meaning
// IDLE   | waiting for start
// FETCH  | instruction read, latch op on mem_ready
// DECODE | one-cycle opcode decode
// EXEC   | ALU add or beq compare
// MEMACC | data read (load) or write (store) until mem_ready
// WB     | register file write-back
// HALT   | halt retired, parked until reset
// ERROR  | illegal opcode or memory timeout, parked until reset
module multicycle_controller #(
   parameter int OP_W        = 3,
   parameter int CNT_W       = 16,
   parameter int MEM_TIMEOUT = 16
) (
   input  logic                   clk,
   input  logic                   reset_n,
   multicycle_controller_if.slave bus
);
   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_FETCH  = 3'd1;
   localparam logic [2:0] S_DECODE = 3'd2;
   localparam logic [2:0] S_EXEC   = 3'd3;
   localparam logic [2:0] S_MEMACC = 3'd4;
   localparam logic [2:0] S_WB     = 3'd5;
   localparam logic [2:0] S_HALT   = 3'd6;
   localparam logic [2:0] S_ERROR  = 3'd7;

   localparam logic [2:0] OP_STORE = 3'b000;
   localparam logic [2:0] OP_LOAD  = 3'b001;
   localparam logic [2:0] OP_ADD   = 3'b010;
   localparam logic [2:0] OP_BEQ   = 3'b101;
   localparam logic [2:0] OP_HALT  = 3'b111;

   localparam int             WT_W    = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
   localparam logic [WT_W-1:0] WT_LOAD = (MEM_TIMEOUT == 0) ? '0 : WT_W'(MEM_TIMEOUT - 1);
   localparam logic [WT_W-1:0] WT_ONE  = WT_W'(1);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic [2:0]       r_state;
   logic [OP_W-1:0]  r_op_q;
   logic [WT_W-1:0]  r_wait_left;
   logic             r_illegal;
   logic             r_timeout;
   logic [CNT_W-1:0] r_instr_count;

   logic [2:0] w_state_nxt;
   logic [2:0] w_op_lo;
   logic       w_op_hi_nz;
   logic       w_retire;
   logic       w_waiting;
   logic       w_set_ill;
   logic       w_set_to;

   assign w_op_lo    = r_op_q[2:0];
   assign w_op_hi_nz = (r_op_q >> 3) != '0;

   always_comb begin
      w_state_nxt = r_state;
      w_retire    = 1'b0;
      w_waiting   = 1'b0;
      w_set_ill   = 1'b0;
      w_set_to    = 1'b0;
      case (r_state)
         S_IDLE:   if (bus.start) w_state_nxt = S_FETCH;
         S_FETCH: begin
            if (bus.mem_ready) w_state_nxt = S_DECODE;
            else               w_waiting   = 1'b1;
         end
         S_DECODE: begin
            if (w_op_hi_nz) begin
               w_state_nxt = S_ERROR;
               w_set_ill   = 1'b1;
            end else begin
               case (w_op_lo)
                  OP_STORE, OP_LOAD: w_state_nxt = S_MEMACC;
                  OP_ADD, OP_BEQ:    w_state_nxt = S_EXEC;
                  OP_HALT: begin
                     w_state_nxt = S_HALT;
                     w_retire    = 1'b1;
                  end
                  default: begin
                     w_state_nxt = S_ERROR;
                     w_set_ill   = 1'b1;
                  end
               endcase
            end
         end
         S_EXEC: begin
            if (w_op_lo == OP_BEQ) begin
               w_state_nxt = S_FETCH;
               w_retire    = 1'b1;
            end else begin
               w_state_nxt = S_WB;
            end
         end
         S_MEMACC: begin
            if (bus.mem_ready) begin
               if (w_op_lo == OP_STORE) begin
                  w_state_nxt = S_FETCH;
                  w_retire    = 1'b1;
               end else begin
                  w_state_nxt = S_WB;
               end
            end else begin
               w_waiting = 1'b1;
            end
         end
         S_WB: begin
            w_state_nxt = S_FETCH;
            w_retire    = 1'b1;
         end
         default: w_state_nxt = r_state;
      endcase
      // a completing access on the terminal wait cycle never reaches here
      if (w_waiting && (MEM_TIMEOUT != 0) && (r_wait_left == '0)) begin
         w_state_nxt = S_ERROR;
         w_set_to    = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_state       <= S_IDLE;
         r_op_q        <= '0;
         r_wait_left   <= WT_LOAD;
         r_illegal     <= 1'b0;
         r_timeout     <= 1'b0;
         r_instr_count <= '0;
      end else begin
         r_state <= w_state_nxt;
         if ((r_state == S_FETCH) && bus.mem_ready) r_op_q <= bus.op;
         if (w_state_nxt != r_state)
            r_wait_left <= WT_LOAD;
         else if (w_waiting && (r_wait_left != '0))
            r_wait_left <= r_wait_left - WT_ONE;
         if (w_set_ill) r_illegal <= 1'b1;
         if (w_set_to)  r_timeout <= 1'b1;
         if (w_retire && (r_instr_count != '1))
            r_instr_count <= r_instr_count + CNT_ONE;
      end
   end

   logic w_mem_read, w_memw, w_ir_en, w_pc_en, w_pc_src, w_regw, w_mem_to_reg;
   logic w_addition, w_aluf, w_branch, w_busy, w_halted;

   always_comb begin
      w_mem_read   = 1'b0;
      w_memw       = 1'b0;
      w_ir_en      = 1'b0;
      w_pc_en      = 1'b0;
      w_pc_src     = 1'b0;
      w_regw       = 1'b0;
      w_mem_to_reg = 1'b0;
      w_addition   = 1'b0;
      w_aluf       = 1'b0;
      w_branch     = 1'b0;
      w_busy       = 1'b0;
      w_halted     = 1'b0;
      case (r_state)
         S_FETCH: begin
            w_busy     = 1'b1;
            w_mem_read = 1'b1;
            w_ir_en    = bus.mem_ready;
            w_pc_en    = bus.mem_ready;
         end
         S_DECODE: w_busy = 1'b1;
         S_EXEC: begin
            w_busy = 1'b1;
            if (w_op_lo == OP_BEQ) begin
               w_aluf   = 1'b1;
               w_branch = 1'b1;
               w_pc_en  = bus.zero;
               w_pc_src = bus.zero;
            end else begin
               w_addition = 1'b1;
            end
         end
         S_MEMACC: begin
            w_busy = 1'b1;
            if (w_op_lo == OP_STORE) w_memw     = 1'b1;
            else                     w_mem_read = 1'b1;
         end
         S_WB: begin
            w_busy       = 1'b1;
            w_regw       = 1'b1;
            w_mem_to_reg = (w_op_lo == OP_LOAD);
         end
         S_HALT:  w_halted = 1'b1;
         default: w_busy   = 1'b0;
      endcase
   end

   assign bus.mem_read    = w_mem_read;
   assign bus.memW        = w_memw;
   assign bus.ir_en       = w_ir_en;
   assign bus.pc_en       = w_pc_en;
   assign bus.pc_src      = w_pc_src;
   assign bus.regW        = w_regw;
   assign bus.mem_to_reg  = w_mem_to_reg;
   assign bus.addition    = w_addition;
   assign bus.aluF        = w_aluf;
   assign bus.branch      = w_branch;
   assign bus.busy        = w_busy;
   assign bus.halted      = w_halted;
   assign bus.illegal     = r_illegal;
   assign bus.timeout     = r_timeout;
   assign bus.instr_count = r_instr_count;
endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench: instruction-level model pushes per-cycle expected outputs,
// a negedge monitor pops and compares against the controller.
module tb_multicycle_controller;
   localparam int OP_W        = 4;
   localparam int CNT_W       = 2;
   localparam int MEM_TIMEOUT = 4;

   localparam logic [13:0] F_MR   = 14'h2000;
   localparam logic [13:0] F_MW   = 14'h1000;
   localparam logic [13:0] F_IR   = 14'h0800;
   localparam logic [13:0] F_PE   = 14'h0400;
   localparam logic [13:0] F_PS   = 14'h0200;
   localparam logic [13:0] F_RW   = 14'h0100;
   localparam logic [13:0] F_M2R  = 14'h0080;
   localparam logic [13:0] F_ADD  = 14'h0040;
   localparam logic [13:0] F_ALUF = 14'h0020;
   localparam logic [13:0] F_BR   = 14'h0010;
   localparam logic [13:0] F_BUSY = 14'h0008;
   localparam logic [13:0] F_HALT = 14'h0004;
   localparam logic [13:0] F_ILL  = 14'h0002;
   localparam logic [13:0] F_TO   = 14'h0001;

   localparam int R_OK = 0, R_HALT = 1, R_ILL = 2, R_TO = 3, R_ABORT = 4;

   logic clk = 1'b0;
   logic reset_n;
   always #5 clk = ~clk;

   multicycle_controller_if #(.OP_W(OP_W), .CNT_W(CNT_W)) bus ();

   multicycle_controller #(.OP_W(OP_W), .CNT_W(CNT_W), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   typedef struct packed {
      logic [13:0]      f;
      logic [CNT_W-1:0] c;
   } exp_t;

   exp_t             exp_q[$];
   int               n_checks = 0;
   int               n_pass   = 0;
   int               cyc_no   = 0;
   logic [CNT_W-1:0] m_count  = '0;
   int               idx;
   int               abort_at;
   bit               aborted;

   function automatic logic [OP_W-1:0] rnd_op();
      return OP_W'($urandom);
   endfunction

   task automatic chk(input bit cond, input string what);
      n_checks++;
      if (cond) n_pass++;
      else $display("FAIL %s at time %0t", what, $time);
   endtask

   // Cycle outside an instruction (IDLE/HALT/ERROR, or a reset from FETCH).
   task automatic tick(input logic st, input logic rn, input logic [13:0] f_i);
      @(posedge clk); #1;
      reset_n       = rn;
      bus.start     = st;
      bus.mem_ready = 1'b0;
      bus.zero      = 1'($urandom);
      bus.op        = rnd_op();
      exp_q.push_back({f_i, m_count});
      if (!rn) m_count = '0;
   endtask

   // Cycle inside an instruction; may be turned into an aborting reset cycle.
   task automatic step(input logic rdy, input logic z, input logic [OP_W-1:0] o,
                       input logic [13:0] f_i, input bit retire);
      if (aborted) return;
      @(posedge clk); #1;
      bus.mem_ready = rdy;
      bus.zero      = z;
      bus.op        = o;
      bus.start     = 1'($urandom);
      exp_q.push_back({f_i, m_count});
      if (idx == abort_at) begin
         reset_n = 1'b0;
         aborted = 1'b1;
         m_count = '0;
      end else begin
         reset_n = 1'b1;
         if (retire && (m_count != '1)) m_count = m_count + CNT_W'(1);
      end
      idx++;
   endtask

   task automatic mem_phase(input int waits, input logic [13:0] f_wait, input logic [13:0] f_done,
                            input logic [OP_W-1:0] o, input bit retire, output bit to);
      to = 1'b0;
      for (int k = 0; k <= waits; k++) begin
         if (k == waits) begin
            step(1'b1, 1'($urandom), o, f_done, retire);
         end else begin
            step(1'b0, 1'($urandom), rnd_op(), f_wait, 1'b0);
            if (k == MEM_TIMEOUT - 1) begin
               to = 1'b1;
               break;
            end
         end
      end
   endtask

   task automatic exec_instr(input logic [OP_W-1:0] o, input int wf, input int wm,
                             input logic z, input int ab, output int res);
      bit         to;
      bit         legal;
      logic [2:0] lo;
      idx      = 0;
      abort_at = ab;
      aborted  = 1'b0;
      lo       = o[2:0];
      legal    = (o[OP_W-1:3] == '0) && (lo inside {3'd0, 3'd1, 3'd2, 3'd5, 3'd7});
      res      = R_OK;
      mem_phase(wf, F_MR | F_BUSY, F_MR | F_IR | F_PE | F_BUSY, o, 1'b0, to);
      if (to) begin
         res = aborted ? R_ABORT : R_TO;
         return;
      end
      step(1'($urandom), 1'($urandom), rnd_op(), F_BUSY, legal && (lo == 3'd7));
      if (!legal) res = R_ILL;
      else begin
         case (lo)
            3'd7: res = R_HALT;
            3'd2: begin
               step(1'($urandom), 1'($urandom), rnd_op(), F_ADD | F_BUSY, 1'b0);
               step(1'($urandom), 1'($urandom), rnd_op(), F_RW | F_BUSY, 1'b1);
            end
            3'd5: step(1'($urandom), z, rnd_op(),
                       F_ALUF | F_BR | F_BUSY | (z ? (F_PE | F_PS) : 14'h0), 1'b1);
            3'd0: begin
               mem_phase(wm, F_MW | F_BUSY, F_MW | F_BUSY, rnd_op(), 1'b1, to);
               if (to) res = R_TO;
            end
            default: begin
               mem_phase(wm, F_MR | F_BUSY, F_MR | F_BUSY, rnd_op(), 1'b0, to);
               if (to) res = R_TO;
               else step(1'($urandom), 1'($urandom), rnd_op(), F_RW | F_M2R | F_BUSY, 1'b1);
            end
         endcase
      end
      if (aborted) res = R_ABORT;
   endtask

   task automatic launch();
      repeat ($urandom_range(0, 2)) tick(1'b0, 1'b1, 14'h0);
      tick(1'b1, 1'b1, 14'h0);
   endtask

   // Park in HALT/ERROR with start pulses, then reset; FETCH if the program ran out.
   task automatic close_seq(input int res);
      logic [13:0] tf;
      if (res == R_ABORT) return;
      if (res == R_OK) begin
         tick(1'b0, 1'b0, F_MR | F_BUSY);
         return;
      end
      tf = (res == R_HALT) ? F_HALT : (res == R_ILL) ? F_ILL : F_TO;
      tick(1'b1, 1'b1, tf);
      repeat ($urandom_range(1, 3)) tick(1'($urandom), 1'b1, tf);
      tick(1'($urandom), 1'b0, tf);
   endtask

   function automatic logic [OP_W-1:0] pick_op();
      int r;
      logic [2:0] legal_ops [4] = '{3'd0, 3'd1, 3'd2, 3'd5};
      r = $urandom_range(0, 99);
      if (r < 82)      return OP_W'(legal_ops[$urandom_range(0, 3)]);
      else if (r < 90) return OP_W'(7);
      else             return rnd_op();
   endfunction

   function automatic int pick_wait();
      return ($urandom_range(0, 99) < 85) ? $urandom_range(0, 3) : $urandom_range(4, 5);
   endfunction

   always @(negedge clk) begin
      exp_t        e;
      logic [13:0] act;
      cyc_no++;
      if (exp_q.size() > 0) begin
         e   = exp_q.pop_front();
         act = {bus.mem_read, bus.memW, bus.ir_en, bus.pc_en, bus.pc_src, bus.regW,
                bus.mem_to_reg, bus.addition, bus.aluF, bus.branch, bus.busy,
                bus.halted, bus.illegal, bus.timeout};
         n_checks++;
         if ((act === e.f) && (bus.instr_count === e.c)) n_pass++;
         else $display("FAIL outputs cycle %0d: got flags=%h count=%0d, expected flags=%h count=%0d",
                       cyc_no, act, bus.instr_count, e.f, e.c);
      end
   end

   initial begin
      int res;
      reset_n       = 1'b0;
      bus.start     = 1'b0;
      bus.op        = '0;
      bus.zero      = 1'b0;
      bus.mem_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk({bus.mem_read, bus.memW, bus.ir_en, bus.pc_en, bus.pc_src, bus.regW,
           bus.mem_to_reg, bus.addition, bus.aluF, bus.branch, bus.busy,
           bus.halted, bus.illegal, bus.timeout} === 14'h0 && bus.instr_count === '0,
          "reset state");

      launch();
      exec_instr(4'b0010, 0, 0, 1'b0, -1, res);
      exec_instr(4'b0001, 0, 3, 1'b0, -1, res);
      exec_instr(4'b0101, 0, 0, 1'b1, -1, res);
      exec_instr(4'b0101, 1, 0, 1'b0, -1, res);
      exec_instr(4'b0000, 0, 2, 1'b0, -1, res);
      exec_instr(4'b0010, 3, 0, 1'b0, -1, res);
      exec_instr(4'b0111, 0, 0, 1'b0, -1, res);
      close_seq(res);

      launch(); exec_instr(4'b0100, 0, 0, 1'b0, -1, res); close_seq(res);
      launch(); exec_instr(4'b1010, 1, 0, 1'b0, -1, res); close_seq(res);

      launch();
      exec_instr(4'b0010, 4, 0, 1'b0, -1, res);
      chk(res == R_TO, "expired wait model result");
      tick(1'b1, 1'b1, F_TO);
      chk(bus.timeout === 1'b1 && bus.busy === 1'b0 && bus.illegal === 1'b0,
          "expired wait");
      repeat (2) tick(1'($urandom), 1'b1, F_TO);
      tick(1'($urandom), 1'b0, F_TO);

      launch(); exec_instr(4'b0000, 0, 4, 1'b0, -1, res); close_seq(res);
      launch(); exec_instr(4'b0111, 0, 0, 1'b0, -1, res); close_seq(res);

      launch();
      exec_instr(4'b0010, 0, 0, 1'b0, -1, res);
      exec_instr(4'b0001, 0, 3, 1'b0, 3, res);
      close_seq(res);

      launch();
      repeat (5) exec_instr(4'b0010, 0, 0, 1'b0, -1, res);
      close_seq(res);

      for (int p = 0; p < 40; p++) begin
         int n_instr;
         launch();
         n_instr = $urandom_range(1, 8);
         res     = R_OK;
         for (int i = 0; i < n_instr && res == R_OK; i++) begin
            exec_instr(pick_op(), pick_wait(), pick_wait(), 1'($urandom),
                       ($urandom_range(0, 99) < 6) ? $urandom_range(0, 5) : -1, res);
         end
         close_seq(res);
      end

      repeat (3) @(posedge clk);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
